contador_32_ctrl: RTL
=====================

Name: contador_32_ctrl

Overview:
- Sequencing controller for a 32-bit counter built from eight cascaded 4-bit counter stages (stage 0 = LSB nibble).
- Accepts commands over a valid/ready handshake: count up, count down, count by 3, or load.
- Drives per-stage enable, mode, D and reset so the eight nibbles behave as one 32-bit counter.
- Reports completion and 32-bit wrap events.

Parameters:
- STAGES, 8, number of 4-bit stages (fixed at 8 for 32 bits).
- STEP_W, 16, width of the step-count field of a command.

Ports:
- clk  in  1  clock; all state changes on posedge.
- reset  in  1  synchronous reset, active-high.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  controller can accept a command (high only in IDLE).
- cmd_op  in  2  0 = up by 1, 1 = down by 1, 2 = up by 3, 3 = load.
- cmd_steps  in  STEP_W  number of count steps (ignored for load).
- cmd_data  in  32  load value for op 3.
- stage_q  in  32  concatenated stage Q outputs; nibble k = bits 4k+3:4k.
- stage_enable  out  8  per-stage enable.
- stage_mode  out  16  per-stage mode; 2 bits per stage.
- stage_d  out  32  per-stage D.
- stage_reset  out  1  shared reset to all stages.
- busy  out  1  high in LOAD, RUN and DONE.
- done  out  1  one-cycle pulse when a command completes.
- wrap32  out  1  one-cycle pulse on 32-bit carry or borrow.
- steps_left  out  STEP_W  remaining steps of the current command.

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high, named reset.
- Reset values (while reset=1): state IDLE, cmd_ready=1, busy=0, done=0, wrap32=0, steps_left=0, stage_enable=0, stage_mode=0, stage_d=0.
- stage_reset = reset, combinational.
- Reset mid-command aborts the command; no done pulse is generated.
- FSM states: IDLE, LOAD, RUN, DONE.
- IDLE: cmd_ready=1. On cmd_valid && cmd_ready, latch op, steps and data.
  - op 3 -> LOAD.
  - steps = 0 -> DONE directly; no enable is issued.
  - otherwise -> RUN, with steps_left = cmd_steps.
- LOAD (1 cycle): all stage_mode = 3, stage_enable = 8'hFF, stage_d = latched data. Next state DONE.
- RUN: one count step per cycle; steps_left decrements each cycle. When steps_left = 1, the next state is DONE.
- DONE (1 cycle): done=1, next state IDLE. Command-to-done latency is N+1 cycles after acceptance for N steps, and 2 cycles for load.
- Per-stage mode in RUN:
  - op 0: all stages mode 0.
  - op 1: all stages mode 1.
  - op 2: stage 0 mode 2, stages 1-7 mode 0.
- Enables in RUN are combinational from state and stage_q:
  - stage_enable[0] = 1.
  - stage_enable[k] = carry[k-1], where carry[k] = stage_enable[k] && term(k).
- term(k) by op:
  - op 0: nibble == 4'hF.
  - op 1: nibble == 4'h0.
  - op 2: stage 0 term = nibble >= 4'hD; stages 1-7 term = nibble == 4'hF.
- wrap32 is registered: it pulses the cycle after a RUN step in which carry[7] = 1.
- Outside RUN and LOAD: stage_enable = 0, stage_mode holds its last value, stage_d = 0.
- The controller never uses the stages' rco outputs; carry is derived only from stage_q.
- cmd_valid while busy is ignored, since cmd_ready=0.

Optional Feature:
- Macro: CONTADOR_CTRL_WRAP_STOP_EN.
- Defined: a wrap in RUN forces DONE on the next cycle regardless of steps_left. steps_left holds its value at the wrap, and done pulses normally.
- Undefined: the counter wraps freely; wrap32 is reported only.

Test Plan:
- Reset, then load 0x0000_000E and up 3 steps -> stage_q = 0x0000_0011; done exactly 4 cycles after acceptance; stage_enable[1] high only on the step from 0xF to 0x10.
- Load 0x0000_0100, down 1 step -> stage_q = 0x0000_00FF; stage_enable = 8'h07 during that step; wrap32 = 0.
- Load 0xFFFF_FFFE, up 3 steps -> stage_q = 0x0000_0001; wrap32 pulses once.
  - With CONTADOR_CTRL_WRAP_STOP_EN: final value 0x0000_0000, steps_left = 1 at done.
- Load 0x0000_000D, op 2 with 2 steps -> 0x0000_0010, then 0x0000_0013; stage 0 mode 2 and stage 1 mode 0 observed.
- Command with steps = 0 -> no stage_enable activity; done 1 cycle after acceptance; cmd_valid held during busy is not accepted twice.
- Assert reset during RUN with steps_left = 5 -> next cycle IDLE, steps_left = 0, stage_reset high, no done pulse.

Source files
------------

// File: rtl/contador_32_ctrl.sv
// Sequencer that drives eight cascaded 4-bit counter stages as one 32-bit counter.
// Build option: define CONTADOR_CTRL_WRAP_STOP_EN to end a RUN command on the first 32-bit wrap.
module contador_32_ctrl #(
    parameter int STAGES = 8,
    parameter int STEP_W = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [1:0]            cmd_op,
    input  logic [STEP_W-1:0]     cmd_steps,
    input  logic [4*STAGES-1:0]   cmd_data,
    input  logic [4*STAGES-1:0]   stage_q,
    output logic [STAGES-1:0]     stage_enable,
    output logic [2*STAGES-1:0]   stage_mode,
    output logic [4*STAGES-1:0]   stage_d,
    output logic                  stage_reset,
    output logic                  busy,
    output logic                  done,
    output logic                  wrap32,
    output logic [STEP_W-1:0]     steps_left
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam logic [1:0] OP_UP   = 2'd0;
    localparam logic [1:0] OP_DOWN = 2'd1;
    localparam logic [1:0] OP_UP3  = 2'd2;
    localparam logic [1:0] OP_LOAD = 2'd3;

    state_t                 state_reg, state_next;
    logic [1:0]             op_reg;
    logic [4*STAGES-1:0]    data_reg;
    logic [STEP_W-1:0]      steps_left_reg, steps_left_next;
    logic [2*STAGES-1:0]    mode_reg, mode_next;
    logic                   wrap32_reg;

    logic [STAGES-1:0]      term;
    logic [STAGES-1:0]      en_run;
    logic [STAGES-1:0]      carry;
    logic [2*STAGES-1:0]    accept_mode;

    // Terminal-count detection per stage is derived from the stage Q value only.
    generate
        for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
            logic [3:0] nib;
            assign nib = stage_q[4*gi +: 4];
            assign term[gi] = (op_reg == OP_DOWN)             ? (nib == 4'h0) :
                              ((op_reg == OP_UP3) && (gi == 0)) ? (nib >= 4'hD) :
                                                                  (nib == 4'hF);
            assign accept_mode[2*gi +: 2] = (cmd_op == OP_DOWN)             ? 2'd1 :
                                            ((cmd_op == OP_UP3) && (gi == 0)) ? 2'd2 :
                                                                                2'd0;
        end
    endgenerate

    // Ripple enable chain: a stage steps only when every lower stage carries out.
    always_comb begin
        en_run = '0;
        carry  = '0;
        for (int k = 0; k < STAGES; k++) begin
            en_run[k] = (k == 0) ? 1'b1 : carry[k-1];
            carry[k]  = en_run[k] & term[k];
        end
    end

    always_comb begin
        state_next      = state_reg;
        steps_left_next = steps_left_reg;
        mode_next       = mode_reg;
        stage_enable    = '0;
        stage_d         = '0;
        cmd_ready       = 1'b0;
        busy            = 1'b1;
        done            = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                cmd_ready = 1'b1;
                busy      = 1'b0;
                if (cmd_valid) begin
                    if (cmd_op == OP_LOAD) begin
                        state_next = ST_LOAD;
                        mode_next  = '1;
                    end else if (cmd_steps == '0) begin
                        state_next      = ST_DONE;
                        steps_left_next = cmd_steps;
                    end else begin
                        state_next      = ST_RUN;
                        steps_left_next = cmd_steps;
                        mode_next       = accept_mode;
                    end
                end
            end
            ST_LOAD: begin
                stage_enable = '1;
                stage_d      = data_reg;
                state_next   = ST_DONE;
            end
            ST_RUN: begin
                stage_enable    = en_run;
                steps_left_next = steps_left_reg - STEP_W'(1);
`ifdef CONTADOR_CTRL_WRAP_STOP_EN
                if ((steps_left_reg == STEP_W'(1)) || carry[STAGES-1]) begin
                    state_next = ST_DONE;
                end
`else
                if (steps_left_reg == STEP_W'(1)) begin
                    state_next = ST_DONE;
                end
`endif
            end
            ST_DONE: begin
                done       = 1'b1;
                state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= ST_IDLE;
            steps_left_reg <= '0;
            mode_reg       <= '0;
            wrap32_reg     <= 1'b0;
            op_reg         <= OP_UP;
            data_reg       <= '0;
        end else begin
            state_reg      <= state_next;
            steps_left_reg <= steps_left_next;
            mode_reg       <= mode_next;
            wrap32_reg     <= (state_reg == ST_RUN) && carry[STAGES-1];
            if ((state_reg == ST_IDLE) && cmd_valid) begin
                op_reg   <= cmd_op;
                data_reg <= cmd_data;
            end
        end
    end

    assign stage_mode  = mode_reg;
    assign stage_reset = reset;
    assign wrap32      = wrap32_reg;
    assign steps_left  = steps_left_reg;

endmodule
